// File: rtl/thunderbird_pkg.sv
// Shared types and lamp decode for the Thunderbird tail-lamp sequencer.
package thunderbird_pkg;

    typedef enum logic [2:0] {IDLE, L1, L2, L3, R1, R2, R3, HAZ_ON} lamp_state_t;

    typedef logic [5:0] lamp_vec_t;

    localparam int unsigned LA = 0;
    localparam int unsigned LB = 1;
    localparam int unsigned LC = 2;
    localparam int unsigned RA = 3;
    localparam int unsigned RB = 4;
    localparam int unsigned RC = 5;

    localparam lamp_vec_t LEFT_MASK  = 6'b000111;
    localparam lamp_vec_t RIGHT_MASK = 6'b111000;

    function automatic lamp_vec_t decode_lamps(input lamp_state_t s);
        lamp_vec_t v;
        v = '0;
        case (s)
            L1: v[LA] = 1'b1;
            L2: begin
                v[LA] = 1'b1;
                v[LB] = 1'b1;
            end
            L3: v = LEFT_MASK;
            R1: v[RA] = 1'b1;
            R2: begin
                v[RA] = 1'b1;
                v[RB] = 1'b1;
            end
            R3: v = RIGHT_MASK;
            HAZ_ON: v = '1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 counter; o_tick is high for the single cycle at DIV-1.
module tick_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic RESET,
    output logic o_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign o_tick = (count == LAST);

endmodule

// File: rtl/thunderbird_lamp_sequencer.sv
// Arbitrates turn/hazard/brake requests and drives the six tail lamps at the
// prescaled step rate; all outputs are registered from next-state logic.
module thunderbird_lamp_sequencer
    import thunderbird_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic RESET,
    input  logic i_TurnLeft,
    input  logic i_TurnRight,
    input  logic i_Hazard,
    input  logic i_Brake,
    output logic o_La,
    output logic o_Lb,
    output logic o_Lc,
    output logic o_Ra,
    output logic o_Rb,
    output logic o_Rc,
    output logic o_Busy
);

    lamp_state_t state;
    lamp_state_t state_next;
    lamp_vec_t   lamps;
    lamp_vec_t   lamps_next;
    logic        busy;
    logic        tick;
    logic        haz;

    tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
        .clk    (clk),
        .RESET  (RESET),
        .o_tick (tick)
    );

    assign haz = i_Hazard | (i_TurnLeft & i_TurnRight);

    always_comb begin
        state_next = state;
        if (tick) begin
            if (haz && (state != HAZ_ON)) begin
                state_next = HAZ_ON;
            end else begin
                case (state)
                    HAZ_ON: state_next = IDLE;
                    IDLE: begin
                        if (i_TurnLeft)       state_next = L1;
                        else if (i_TurnRight) state_next = R1;
                    end
                    L1:      state_next = L2;
                    L2:      state_next = L3;
                    L3:      state_next = IDLE;
                    R1:      state_next = R2;
                    R2:      state_next = R3;
                    R3:      state_next = IDLE;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Brake lights whichever side is not sequencing; hazard (on or off phase) masks it.
    always_comb begin
        lamps_next = decode_lamps(state_next);
        if (i_Brake) begin
            case (state_next)
                IDLE:       if (!haz) lamps_next = '1;
                L1, L2, L3: lamps_next = lamps_next | RIGHT_MASK;
                R1, R2, R3: lamps_next = lamps_next | LEFT_MASK;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            lamps <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            lamps <= lamps_next;
            busy  <= (state_next != IDLE);
        end
    end

    assign o_La   = lamps[LA];
    assign o_Lb   = lamps[LB];
    assign o_Lc   = lamps[LC];
    assign o_Ra   = lamps[RA];
    assign o_Rb   = lamps[RB];
    assign o_Rc   = lamps[RC];
    assign o_Busy = busy;

endmodule

// File: tb/tb_thunderbird_lamp_sequencer.sv
// Directed bench for the lamp sequencer at TICK_DIV = 2, 1 and 4.
module tb_thunderbird_lamp_sequencer;

    // Observed vector layout: {busy, Rc, Rb, Ra, Lc, Lb, La}
    localparam logic [6:0] OFF  = 7'b0000000;
    localparam logic [6:0] L1V  = 7'b1000001;
    localparam logic [6:0] L2V  = 7'b1000011;
    localparam logic [6:0] L3V  = 7'b1000111;
    localparam logic [6:0] R1V  = 7'b1001000;
    localparam logic [6:0] R2V  = 7'b1011000;
    localparam logic [6:0] R3V  = 7'b1111000;
    localparam logic [6:0] HAZV = 7'b1111111;
    localparam logic [6:0] BRK  = 7'b0111111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic tl2 = 1'b0, tr2 = 1'b0, hz2 = 1'b0, br2 = 1'b0;
    logic tl1 = 1'b0, tr1 = 1'b0;
    logic tl4 = 1'b0, tr4 = 1'b0;
    logic [6:0] out2, out1, out4;

    int checks = 0;
    int errors = 0;

    thunderbird_lamp_sequencer #(.TICK_DIV(2)) dut2 (
        .clk(clk), .RESET(rst),
        .i_TurnLeft(tl2), .i_TurnRight(tr2), .i_Hazard(hz2), .i_Brake(br2),
        .o_La(out2[0]), .o_Lb(out2[1]), .o_Lc(out2[2]),
        .o_Ra(out2[3]), .o_Rb(out2[4]), .o_Rc(out2[5]), .o_Busy(out2[6])
    );

    thunderbird_lamp_sequencer #(.TICK_DIV(1)) dut1 (
        .clk(clk), .RESET(rst),
        .i_TurnLeft(tl1), .i_TurnRight(tr1), .i_Hazard(1'b0), .i_Brake(1'b0),
        .o_La(out1[0]), .o_Lb(out1[1]), .o_Lc(out1[2]),
        .o_Ra(out1[3]), .o_Rb(out1[4]), .o_Rc(out1[5]), .o_Busy(out1[6])
    );

    thunderbird_lamp_sequencer #(.TICK_DIV(4)) dut4 (
        .clk(clk), .RESET(rst),
        .i_TurnLeft(tl4), .i_TurnRight(tr4), .i_Hazard(1'b0), .i_Brake(1'b0),
        .o_La(out4[0]), .o_Lb(out4[1]), .o_Lc(out4[2]),
        .o_Ra(out4[3]), .o_Rb(out4[4]), .o_Rc(out4[5]), .o_Busy(out4[6])
    );

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance to the negedge after the next TICK_DIV=2 tick and check dut2.
    task automatic tick2(input string tag, input logic [6:0] exp);
        repeat (2) @(negedge clk);
        check(tag, out2, exp);
    endtask

    initial begin
        logic [6:0] left_seq [8];
        left_seq = '{L1V, L2V, L3V, OFF, L1V, L2V, L3V, OFF};

        // Reset and first-tick latency
        repeat (2) @(negedge clk);
        check("reset_hold", out2, OFF);
        rst = 1'b0;
        tl2 = 1'b1;
        @(negedge clk);
        check("no_tick_cycle1", out2, OFF);
        @(negedge clk);
        check("first_tick_l1", out2, left_seq[0]);

        // Left sequence held for 8 ticks
        for (int i = 1; i < 8; i++) tick2("left_seq", left_seq[i]);
        tick2("left_again_l1", L1V);
        tick2("left_again_l2", L2V);
        tl2 = 1'b0;
        tick2("drop_l3", L3V);
        tick2("drop_off", OFF);
        tick2("drop_stay_off", OFF);

        // Left+Right together behaves as hazard
        tl2 = 1'b1;
        tr2 = 1'b1;
        tick2("lr_haz_on", HAZV);
        tick2("lr_haz_off", OFF);
        tick2("lr_haz_on2", HAZV);
        tick2("lr_haz_off2", OFF);
        tl2 = 1'b0;
        tr2 = 1'b0;

        // Hazard preempts right sequence at R2
        tr2 = 1'b1;
        tick2("right_r1", R1V);
        tick2("right_r2", R2V);
        hz2 = 1'b1;
        tick2("preempt_haz", HAZV);
        hz2 = 1'b0;
        tr2 = 1'b0;
        tick2("haz_to_idle", OFF);
        tick2("idle_stays", OFF);

        // Brake overlay
        br2 = 1'b1;
        @(negedge clk);
        check("brake_idle", out2, BRK);
        tr2 = 1'b1;
        @(negedge clk);
        check("brake_r1", out2, R1V | 7'b0000111);
        tick2("brake_r2", R2V | 7'b0000111);
        tick2("brake_r3", R3V | 7'b0000111);
        tr2 = 1'b0;
        tick2("brake_idle2", BRK);
        tick2("brake_idle3", BRK);
        hz2 = 1'b1;
        @(negedge clk);
        check("brake_haz_idle", out2, OFF);
        @(negedge clk);
        check("brake_haz_on", out2, HAZV);
        tick2("brake_haz_off", OFF);
        tick2("brake_haz_on2", HAZV);
        hz2 = 1'b0;
        br2 = 1'b0;
        tick2("brake_release", OFF);

        // Asynchronous reset mid-L3, restart on first tick after release
        tl2 = 1'b1;
        tick2("pre_rst_l1", L1V);
        tick2("pre_rst_l2", L2V);
        tick2("pre_rst_l3", L3V);
        #2 rst = 1'b1;
        #1 check("async_reset", out2, OFF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_c1", out2, OFF);
        @(negedge clk);
        check("restart_l1", out2, L1V);
        tl2 = 1'b0;
        tick2("restart_l2", L2V);
        tick2("restart_l3", L3V);
        tick2("restart_off", OFF);

        // TICK_DIV=4: pulse between ticks ignored, held request taken at tick
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tl4 = 1'b1;
        @(negedge clk);
        tl4 = 1'b0;
        check("div4_pulse_c2", out4, OFF);
        repeat (6) @(negedge clk);
        check("div4_pulse_ignored", out4, OFF);
        tl4 = 1'b1;
        repeat (3) @(negedge clk);
        check("div4_before_tick", out4, OFF);
        @(negedge clk);
        check("div4_tick_l1", out4, L1V);
        tl4 = 1'b0;

        // TICK_DIV=1: steps every cycle
        tr1 = 1'b1;
        @(negedge clk);
        check("div1_r1", out1, R1V);
        tr1 = 1'b0;
        @(negedge clk);
        check("div1_r2", out1, R2V);
        @(negedge clk);
        check("div1_r3", out1, R3V);
        @(negedge clk);
        check("div1_idle", out1, OFF);
        @(negedge clk);
        check("div1_stay", out1, OFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
